// File: rtl/miss_refill_ctrl_pkg.sv
// ============================================================================
// Module      : miss_refill_ctrl_pkg
// Description : Shared FSM state type and access-mode decoding for the
//               miss/refill controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package miss_refill_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    REFILL = 2'd2,
    WR_REQ = 2'd3
  } state_t;

  localparam logic [3:0] c_mode_rd_0  = 4'b0000;
  localparam logic [3:0] c_mode_rd_1  = 4'b0001;
  localparam logic [3:0] c_mode_rd_2  = 4'b0010;
  localparam logic [3:0] c_mode_rd_5  = 4'b0101;
  localparam logic [3:0] c_mode_rd_6  = 4'b0110;
  localparam logic [3:0] c_mode_write = 4'b0111;

  function automatic logic is_read(input logic [3:0] mode);
    logic r;
    case (mode)
      c_mode_rd_0, c_mode_rd_1, c_mode_rd_2, c_mode_rd_5, c_mode_rd_6: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_write(input logic [3:0] mode);
    return (mode == c_mode_write);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
// ============================================================================
// Module      : mem_timeout_ctr
// Description : Saturating memory wait counter; flags expiry on the wait
//               cycle that brings the count up to TIMEOUT_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic increment,
  output logic expired
);

  localparam int c_cnt_w = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT_CYCLES);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  logic [c_cnt_w-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (increment && (r_count != c_limit)) begin
      r_count <= r_count + c_one;
    end
  end

  // Expiry is flagged in the same cycle as the increment that reaches the limit
  assign expired = increment && (r_count >= c_last);

endmodule

`default_nettype wire

// File: rtl/miss_refill_ctrl.sv
// ============================================================================
// Module      : miss_refill_ctrl
// Description : Write-through cache miss/refill controller with memory
//               request handshake and sticky timeout error.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module miss_refill_ctrl
  import miss_refill_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            AddrMode,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] WD,
  input  logic                  hit,
  output logic                  stall,
  output logic                  refill_valid,
  output logic [ADDR_WIDTH-1:0] refill_addr,
  output logic [DATA_WIDTH-1:0] refill_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_error
);

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_error;

  logic w_latch_addr;
  logic w_latch_wdata;
  logic w_capture;
  logic w_set_error;
  logic w_wait;
  logic w_clear;
  logic w_expired;
  logic w_unused_lsbs;

  // Byte offset is resolved by the load path, not here
  assign w_unused_lsbs = ^A[1:0];

  assign w_wait  = ((r_state == RD_REQ) || (r_state == WR_REQ)) && !mem_ready;
  assign w_clear = (r_state == IDLE);

  mem_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_clear),
    .increment (w_wait),
    .expired   (w_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    stall         = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    refill_valid  = 1'b0;
    w_latch_addr  = 1'b0;
    w_latch_wdata = 1'b0;
    w_capture     = 1'b0;
    w_set_error   = 1'b0;
    case (r_state)
      IDLE: begin
        // Gating with reset keeps stall low while the block is held in reset
        if (reset) begin
          if (is_write(AddrMode)) begin
            w_next_state  = WR_REQ;
            w_latch_addr  = 1'b1;
            w_latch_wdata = 1'b1;
            stall         = 1'b1;
          end else if (is_read(AddrMode) && !hit) begin
            w_next_state = RD_REQ;
            w_latch_addr = 1'b1;
            stall        = 1'b1;
          end
        end
      end
      RD_REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) begin
          w_capture    = 1'b1;
          w_next_state = REFILL;
        end else if (w_expired) begin
          w_set_error  = 1'b1;
          w_next_state = IDLE;
        end
      end
      REFILL: begin
        refill_valid = 1'b1;
        w_next_state = IDLE;
      end
      WR_REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) begin
          w_next_state = IDLE;
        end else if (w_expired) begin
          w_set_error  = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_latch_addr) begin
        r_addr <= {A[ADDR_WIDTH-1:2], 2'b00};
      end
      if (w_latch_wdata) begin
        r_wdata <= WD;
      end
      if (w_capture) begin
        r_rdata <= mem_rdata;
      end
      if (w_set_error) begin
        r_error <= 1'b1;
      end
    end
  end

  assign refill_addr = r_addr;
  assign refill_data = r_rdata;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign mem_error   = r_error;

endmodule

`default_nettype wire

// File: tb/tb_miss_refill_ctrl.sv
// ============================================================================
// Module      : tb_miss_refill_ctrl
// Description : Transaction-level random and directed bench for miss_refill_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_miss_refill_ctrl;

  localparam int c_aw  = 32;
  localparam int c_dw  = 32;
  localparam int c_tmo = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      AddrMode;
  logic [c_aw-1:0] A;
  logic [c_dw-1:0] WD;
  logic            hit;
  logic            stall;
  logic            refill_valid;
  logic [c_aw-1:0] refill_addr;
  logic [c_dw-1:0] refill_data;
  logic            mem_req;
  logic            mem_we;
  logic [c_aw-1:0] mem_addr;
  logic [c_dw-1:0] mem_wdata;
  logic            mem_ready;
  logic [c_dw-1:0] mem_rdata;
  logic            mem_error;

  miss_refill_ctrl #(
    .ADDR_WIDTH     (c_aw),
    .DATA_WIDTH     (c_dw),
    .TIMEOUT_CYCLES (c_tmo)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .AddrMode     (AddrMode),
    .A            (A),
    .WD           (WD),
    .hit          (hit),
    .stall        (stall),
    .refill_valid (refill_valid),
    .refill_addr  (refill_addr),
    .refill_data  (refill_data),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .mem_error    (mem_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: sticky error and the last address/write data sent to memory
  logic            m_err;
  logic [c_aw-1:0] m_addr;
  logic [c_dw-1:0] m_wdata;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic mdl_is_read(input logic [3:0] m);
    return (m == 4'd0) || (m == 4'd1) || (m == 4'd2) || (m == 4'd5) || (m == 4'd6);
  endfunction

  task automatic scramble_inputs();
    AddrMode = 4'($urandom);
    A        = $urandom;
    WD       = $urandom;
    hit      = 1'($urandom);
  endtask

  // Entered and left just after a rising edge. delay = wait cycle carrying
  // mem_ready; a delay beyond c_tmo means memory never answers.
  task automatic run_op(input logic [3:0] mode, input logic [c_aw-1:0] addr,
                        input logic [c_dw-1:0] wd, input logic h,
                        input int delay, input logic [c_dw-1:0] rd);
    logic is_wr;
    logic start;
    logic served;
    logic [c_aw-1:0] exp_addr;
    is_wr    = (mode == 4'b0111);
    start    = is_wr || (mdl_is_read(mode) && !h);
    exp_addr = {addr[c_aw-1:2], 2'b00};
    AddrMode = mode; A = addr; WD = wd; hit = h; mem_ready = 1'b0;
    @(negedge clk);
    check_eq("idle_stall", 64'(stall), 64'(start));
    check_eq("idle_req", 64'(mem_req), 64'd0);
    check_eq("idle_refill", 64'(refill_valid), 64'd0);
    if (!start) begin
      check_eq("idle_addr_hold", 64'(mem_addr), 64'(m_addr));
      @(posedge clk); #1;
      return;
    end
    m_addr = exp_addr;
    if (is_wr) m_wdata = wd;
    served = 1'b0;
    for (int i = 1; i <= c_tmo && !served; i++) begin
      @(posedge clk); #1;
      scramble_inputs();
      mem_ready = (i == delay);
      mem_rdata = (i == delay) ? rd : $urandom;
      @(negedge clk);
      check_eq("wait_req", 64'(mem_req), 64'd1);
      check_eq("wait_we", 64'(mem_we), 64'(is_wr));
      check_eq("wait_addr", 64'(mem_addr), 64'(exp_addr));
      check_eq("wait_stall", 64'(stall), 64'd1);
      check_eq("wait_err", 64'(mem_error), 64'(m_err));
      if (is_wr) check_eq("wait_wdata", 64'(mem_wdata), 64'(wd));
      if (i == delay) served = 1'b1;
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
    if (!served) m_err = 1'b1;
    if (served && !is_wr) begin
      scramble_inputs();
      @(negedge clk);
      check_eq("refill_valid", 64'(refill_valid), 64'd1);
      check_eq("refill_addr", 64'(refill_addr), 64'(exp_addr));
      check_eq("refill_data", 64'(refill_data), 64'(rd));
      check_eq("refill_stall", 64'(stall), 64'd0);
      check_eq("refill_req", 64'(mem_req), 64'd0);
      check_eq("refill_err", 64'(mem_error), 64'(m_err));
    end else begin
      AddrMode = 4'hF; hit = 1'b0;
      @(negedge clk);
      check_eq("post_stall", 64'(stall), 64'd0);
      check_eq("post_req", 64'(mem_req), 64'd0);
      check_eq("post_we", 64'(mem_we), 64'd0);
      check_eq("post_refill", 64'(refill_valid), 64'd0);
      check_eq("post_err", 64'(mem_error), 64'(m_err));
      check_eq("post_addr", 64'(mem_addr), 64'(m_addr));
      check_eq("post_wdata", 64'(mem_wdata), 64'(m_wdata));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; AddrMode = 4'hF; A = '0; WD = '0; hit = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    m_err = 1'b0; m_addr = '0; m_wdata = '0;
    #3;
    check_eq("rst_stall", 64'(stall), 64'd0);
    check_eq("rst_req", 64'(mem_req), 64'd0);
    check_eq("rst_we", 64'(mem_we), 64'd0);
    check_eq("rst_refill", 64'(refill_valid), 64'd0);
    check_eq("rst_err", 64'(mem_error), 64'd0);
    check_eq("rst_maddr", 64'(mem_addr), 64'd0);
    check_eq("rst_mwdata", 64'(mem_wdata), 64'd0);
    check_eq("rst_raddr", 64'(refill_addr), 64'd0);
    check_eq("rst_rdata", 64'(refill_data), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Directed: hit, miss with late ready, write straight after refill, timeout
    run_op(4'b0010, 32'h0000_0100, 32'h0, 1'b1, 1, 32'h0);
    run_op(4'b0000, 32'h0000_1236, 32'h0, 1'b0, 3, 32'hDEAD_BEEF);
    run_op(4'b0111, 32'h0000_0040, 32'hA5A5_A5A5, 1'b1, 1, 32'h0);
    run_op(4'b0001, 32'h0000_0888, 32'h0, 1'b0, c_tmo + 1, 32'h0);
    run_op(4'b0101, 32'h0000_2000, 32'h0, 1'b0, 1, 32'h1357_9BDF);

    // Reset in the middle of a read request
    AddrMode = 4'b0110; A = 32'h0000_3003; hit = 1'b0;
    @(posedge clk); #1;
    scramble_inputs();
    @(negedge clk);
    check_eq("mid_req_before", 64'(mem_req), 64'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("mid_req_after", 64'(mem_req), 64'd0);
    check_eq("mid_stall", 64'(stall), 64'd0);
    check_eq("mid_refill", 64'(refill_valid), 64'd0);
    check_eq("mid_err", 64'(mem_error), 64'd0);
    check_eq("mid_addr", 64'(mem_addr), 64'd0);
    m_err = 1'b0; m_addr = '0; m_wdata = '0;
    AddrMode = 4'hF; hit = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    run_op(4'b0010, 32'h0000_4447, 32'h0, 1'b0, 2, 32'hCAFE_F00D);

    for (int n = 0; n < 200; n++) begin
      run_op(4'($urandom), $urandom, $urandom, 1'($urandom),
             int'($urandom_range(1, c_tmo + 2)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
